mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified byte-addressed memory between the core's instruction-fetch port and its load/store port.
- Arbitrates once per cycle and drives the memory's address, write-enable and byte-lane controls.
- Tags each issued read and routes the registered read data back to its owner one cycle later; sign/zero-extends load data.
- Sits between the core pipeline and the memory. Replaces the memory's separate combinational fetch path.

Parameters:
- STARVE_MAX, 4: max consecutive data grants while a fetch is pending before the fetch is forced through (1..15).
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- if_req_valid  in  1  fetch request
- if_addr  in  ADDR_W  fetch byte address
- if_req_ready  out  1  fetch accepted this cycle
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
- if_rsp_data  out  32  instruction word
- d_req_valid  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- d_signed  in  1  sign-extend load
- d_addr  in  ADDR_W  byte address
- d_wdata  in  32  store data, LSB-aligned
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  load data/error valid (1-cycle pulse)
- d_rsp_data  out  32  extended load data
- d_rsp_err  out  1  access rejected
- mem_addr  out  ADDR_W  memory byte address
- mem_rd_en  out  1  read issued
- mem_wr_en  out  1  write issued
- mem_be  out  4  byte lanes; bit i writes byte addr+i
- mem_wdata  out  32  store data
- mem_rdata  in  32  {m[a+3],m[a+2],m[a+1],m[a]}, registered; valid the cycle after mem_rd_en

Behaviour:
- **Throughput:** one issue per cycle, fully pipelined. Reads have 1-cycle latency; stores complete at acceptance with no response. Responses cannot be back-pressured.
- **Ready signals:** combinational from the valids and the starvation counter. A request transfers when valid & ready.
- **Arbitration:**
  - Data wins over fetch.
  - Exception: fetch wins if if_req_valid && starve_cnt == STARVE_MAX.
  - starve_cnt increments on each data grant while if_req_valid is high.
  - starve_cnt clears on a fetch grant or when if_req_valid is low.
  - starve_cnt saturates at STARVE_MAX.
- **Lane generation:** mem_be = 0001 / 0011 / 1111 for d_size 0 / 1 / 2. A fetch uses 1111 with mem_rd_en set. mem_wdata = d_wdata, unshifted.
- **Response tag register:**
  - Fields: {owner: NONE/IF/D, size, signed}, captured on each read issue.
  - Next cycle: owner IF → if_rsp_valid with raw mem_rdata.
  - Owner D → d_rsp_valid; byte/half responses are extended per the captured signed bit.
  - Owner NONE → no response pulse.
- **Illegal d_size = 3:** not issued to memory. d_req_ready is asserted, then d_rsp_valid = 1 and d_rsp_err = 1 in the next cycle, for both loads and stores.
- **Idle cycle:** mem_rd_en = mem_wr_en = 0, mem_be = 0.
- **Reset:** all outputs 0, tag = NONE, starve_cnt = 0. A read in flight when rst is asserted produces no response after reset.
- **Simultaneous events:** both requesters valid with the starvation limit hit → the fetch issues and the data request waits, d_req_ready = 0.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHK_EN
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, is accepted but not issued to memory. d_rsp_valid = 1 and d_rsp_err = 1 the next cycle. A fetch with if_addr[1:0] != 0 returns if_rsp_data = 0.
- Undefined: misaligned accesses pass through unchanged; the memory handles byte-granular addressing.

Decomposition:
- Shared package mem_arb_pkg:
  - owner enum {OWN_NONE, OWN_IF, OWN_D}
  - size constants SZ_B / SZ_H / SZ_W
  - be lookup function
  - load-extend function
- Sub-module mem_arb_prio: combinational grant logic plus the starvation counter. It outputs gnt_if and gnt_d.

Test Plan:
- Reset then idle, with no requests: all outputs remain 0 and mem_be = 0.
- Store word 0xDEADBEEF to 0x100, then load byte signed from 0x100 and half unsigned from 0x102 → d_rsp_data = 0xFFFFFFEF, then 0x0000DEAD, each one cycle after acceptance.
- Both ports valid continuously with STARVE_MAX = 4 → grant pattern D, D, D, D, IF repeating; each if_rsp_valid carries the word at the granted address.
- Back-to-back: fetch 0x0, data load 0x10, fetch 0x4 on consecutive cycles → responses on consecutive cycles routed to the correct owners.
- d_size = 3 store → no mem_wr_en, d_rsp_err pulse. With MEM_ARB_ALIGN_CHK_EN, a word load at 0x102 → d_rsp_err = 1 and mem_rd_en = 0.
- rst asserted the cycle after a load issue → no d_rsp_valid; all outputs 0 the following cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified-memory port arbiter: response tag,
// access-size codes, byte-lane lookup and load extension.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SZ_B   = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H   = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W   = 2'd2;
    localparam logic [SIZE_W-1:0] SZ_ILL = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // err marks a response that carries no memory data (rejected / zeroed)
    typedef struct packed {
        owner_e             owner;
        logic [SIZE_W-1:0]  size;
        logic               sgn;
        logic               err;
    } rsp_tag_t;

    localparam rsp_tag_t TAG_IDLE = '{owner: OWN_NONE, size: SZ_B, sgn: 1'b0, err: 1'b0};

    function automatic logic [BE_W-1:0] be_of(input logic [SIZE_W-1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                   input logic [SIZE_W-1:0] size,
                                                   input logic              sgn);
        logic [DATA_W-1:0] r;
        case (size)
            SZ_B:    r = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
            SZ_H:    r = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the port arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;

    logic              d_req_valid;
    logic              d_we;
    logic [SIZE_W-1:0] d_size;
    logic              d_signed;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              d_rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  if_req_valid, if_addr, d_req_valid, d_we, d_size, d_signed, d_addr, d_wdata, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
               mem_addr, mem_rd_en, mem_wr_en, mem_be, mem_wdata
    );

    // core pipeline plus memory
    modport master (
        output if_req_valid, if_addr, d_req_valid, d_we, d_size, d_signed, d_addr, d_wdata, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
               mem_addr, mem_rd_en, mem_wr_en, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Data-over-fetch grant logic with a saturating starvation counter that forces
// a pending fetch through after STARVE_MAX consecutive data grants.
module mem_arb_prio #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic d_valid,
    output logic gnt_if,
    output logic gnt_d
);
    localparam int unsigned      CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;

    always_comb begin
        gnt_if         = 1'b0;
        gnt_d          = 1'b0;
        starve_cnt_nxt = starve_cnt;
        if (!rst) begin
            gnt_if = if_valid && (!d_valid || (starve_cnt == CNT_MAX));
            gnt_d  = d_valid && !gnt_if;
        end
        if (!if_valid || gnt_if) begin
            starve_cnt_nxt = '0;
        end else if (gnt_d && (starve_cnt != CNT_MAX)) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_cnt <= '0;
        else     starve_cnt <= starve_cnt_nxt;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory between fetch and load/store ports; tags reads
// and routes the registered read data back one cycle later. Alignment checking
// is enabled by defining MEM_ARB_ALIGN_CHK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    logic              gnt_if;
    logic              gnt_d;
    logic              d_illegal;
    logic              d_misal;
    logic              if_misal;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss_rd;
    logic              iss_wr;
    logic [BE_W-1:0]   iss_be;
    logic [DATA_W-1:0] iss_wdata;
    rsp_tag_t          tag_d;
    rsp_tag_t          tag_q;

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_valid (bus.if_req_valid),
        .d_valid  (bus.d_req_valid),
        .gnt_if   (gnt_if),
        .gnt_d    (gnt_d)
    );

    // issue decode: memory controls for this cycle and the tag for next cycle
    always_comb begin
        d_illegal = bus.d_size == SZ_ILL;
`ifdef MEM_ARB_ALIGN_CHK_EN
        d_misal   = misaligned(bus.d_size, bus.d_addr[1:0]);
        if_misal  = bus.if_addr[1:0] != 2'b00;
`else
        d_misal   = 1'b0;
        if_misal  = 1'b0;
`endif
        iss_addr  = '0;
        iss_rd    = 1'b0;
        iss_wr    = 1'b0;
        iss_be    = '0;
        iss_wdata = '0;
        tag_d     = TAG_IDLE;
        if (gnt_if) begin
            tag_d.owner = OWN_IF;
            tag_d.err   = if_misal;
            if (!if_misal) begin
                iss_addr = bus.if_addr;
                iss_rd   = 1'b1;
                iss_be   = be_of(SZ_W);
            end
        end else if (gnt_d) begin
            if (d_illegal || d_misal) begin
                tag_d.owner = OWN_D;
                tag_d.err   = 1'b1;
            end else begin
                iss_addr = bus.d_addr;
                iss_be   = be_of(bus.d_size);
                if (bus.d_we) begin
                    iss_wr    = 1'b1;
                    iss_wdata = bus.d_wdata;
                end else begin
                    iss_rd      = 1'b1;
                    tag_d.owner = OWN_D;
                    tag_d.size  = bus.d_size;
                    tag_d.sgn   = bus.d_signed;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tag_q <= TAG_IDLE;
        else     tag_q <= tag_d;
    end

    assign bus.if_req_ready = gnt_if;
    assign bus.d_req_ready  = gnt_d;
    assign bus.mem_addr     = iss_addr;
    assign bus.mem_rd_en    = iss_rd;
    assign bus.mem_wr_en    = iss_wr;
    assign bus.mem_be       = iss_be;
    assign bus.mem_wdata    = iss_wdata;

    // response routing; gating with rst drops a read that was in flight at reset
    always_comb begin
        bus.if_rsp_valid = !rst && (tag_q.owner == OWN_IF);
        bus.d_rsp_valid  = !rst && (tag_q.owner == OWN_D);
        bus.d_rsp_err    = bus.d_rsp_valid && tag_q.err;
        bus.if_rsp_data  = (bus.if_rsp_valid && !tag_q.err) ? bus.mem_rdata : '0;
        bus.d_rsp_data   = (bus.d_rsp_valid && !tag_q.err)
                         ? load_ext(bus.mem_rdata, tag_q.size, tag_q.sgn) : '0;
    end

endmodule
